prio_arbiter4: RTL and testbench

Four-requester arbiter that shares one downstream resource, with the requester index coded in the same 3-bit priority code used by the priority encoders (100 = requester 4 … 001 = requester 1, 000 = none). Default priority is fixed: requester 4 is highest. A grant is held until the owner drops its request. A hold timer forcibly revokes grants that run too long. The block sits between the requesting agents and the shared resource's select/enable inputs.

---
 rtl/prio_arbiter4.sv | 127 ++++++++++++
 tb/tb_prio_arbiter4.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter4.sv
// Four-requester arbiter with grant hold, hold-timeout revocation and per-requester masking.
// Define ARB_RR_EN for round-robin priority; otherwise fixed priority 4 > 3 > 2 > 1.
module prio_arbiter4 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:1] req,
  output logic [4:1] grant,
  output logic [2:0] gcode,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit         TO_EN  = (HOLD_MAX != 0);
  localparam logic [7:0] TO_CNT = TO_EN ? 8'(HOLD_MAX - 1) : '0;

  state_t     state, state_nx;
  logic [3:0] rq, elig, mask, mask_nx, grant_nx;
  logic [1:0] owner, owner_nx, win;
  logic       win_vld;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] gcode_nx;
  logic       timeout_nx;

  // Internal indices are requester number minus one.
  assign rq   = req;
  assign elig = rq & ~mask;

`ifdef ARB_RR_EN
  logic [1:0] ptr;

  // Search starts just below the last winner and wraps, so the last winner is checked last.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned j = 1; j <= 4; j++) begin
      if (!win_vld && elig[ptr - 2'(j)]) begin
        win     = ptr - 2'(j);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (state == IDLE && win_vld)
      ptr <= win;
  end
`else
  always_comb begin
    win     = '0;
    win_vld = |elig;
    for (int unsigned j = 0; j < 4; j++) begin
      if (elig[j]) win = 2'(j);
    end
  end
`endif

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    cnt_nx     = cnt;
    grant_nx   = grant;
    gcode_nx   = gcode;
    timeout_nx = 1'b0;
    mask_nx    = mask & rq;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nx = GRANT;
          owner_nx = win;
          cnt_nx   = '0;
          grant_nx = 4'b0001 << win;
          gcode_nx = 3'(win) + 3'd1;
        end
      end
      GRANT: begin
        // Release takes precedence over a timeout on the same edge.
        if (!rq[owner]) begin
          state_nx = IDLE;
          grant_nx = '0;
          gcode_nx = '0;
        end else if (TO_EN && cnt == TO_CNT) begin
          state_nx       = IDLE;
          grant_nx       = '0;
          gcode_nx       = '0;
          timeout_nx     = 1'b1;
          mask_nx[owner] = 1'b1;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        gcode_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      cnt     <= '0;
      mask    <= '0;
      grant   <= '0;
      gcode   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      cnt     <= cnt_nx;
      mask    <= mask_nx;
      grant   <= grant_nx;
      gcode   <= gcode_nx;
      busy    <= (state_nx == GRANT);
      timeout <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_prio_arbiter4.sv
// Directed bench for prio_arbiter4: three instances with HOLD_MAX = 0, 4 and 3.
module tb_prio_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [4:1] req_h0, req_h4, req_h3;
  logic [4:1] grant_h0, grant_h4, grant_h3;
  logic [2:0] gcode_h0, gcode_h4, gcode_h3;
  logic       busy_h0, busy_h4, busy_h3;
  logic       timeout_h0, timeout_h4, timeout_h3;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  prio_arbiter4 #(.HOLD_MAX(0)) u_h0 (
    .clk(clk), .rst_n(rst_n), .req(req_h0), .grant(grant_h0),
    .gcode(gcode_h0), .busy(busy_h0), .timeout(timeout_h0)
  );
  prio_arbiter4 #(.HOLD_MAX(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req_h4), .grant(grant_h4),
    .gcode(gcode_h4), .busy(busy_h4), .timeout(timeout_h4)
  );
  prio_arbiter4 #(.HOLD_MAX(3)) u_h3 (
    .clk(clk), .rst_n(rst_n), .req(req_h3), .grant(grant_h3),
    .gcode(gcode_h3), .busy(busy_h3), .timeout(timeout_h3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [3:0] rr_exp  [5];
  logic [2:0] rr_code [5];
  logic       bad;

  initial begin
`ifdef ARB_RR_EN
    rr_exp  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    rr_code = '{3'b100, 3'b011, 3'b010, 3'b001, 3'b100};
`else
    rr_exp  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    rr_code = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif
    rst_n  = 1'b0;
    req_h0 = '0;
    req_h4 = '0;
    req_h3 = '0;
    tick();
    tick();
    check("rst_grant",   8'(grant_h0),   8'h0);
    check("rst_gcode",   8'(gcode_h0),   8'h0);
    check("rst_busy",    8'(busy_h0),    8'h0);
    check("rst_timeout", 8'(timeout_h0), 8'h0);
    rst_n = 1'b1;

    // Single request, grant and release latency
    req_h0 = 4'b0010;
    tick();
    check("single_grant", 8'(grant_h0), 8'b0010);
    check("single_gcode", 8'(gcode_h0), 8'b010);
    check("single_busy",  8'(busy_h0),  8'h1);
    req_h0 = 4'b0000;
    tick();
    check("single_release", 8'(grant_h0), 8'h0);
    check("single_idle",    8'(busy_h0),  8'h0);
    check("single_gc_idle", 8'(gcode_h0), 8'h0);

    // Contention, no timeout
    req_h0 = 4'b1111;
    tick();
    check("cont_grant", 8'(grant_h0), 8'b1000);
    check("cont_gcode", 8'(gcode_h0), 8'b100);
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (grant_h0 !== 4'b1000 || timeout_h0 !== 1'b0) bad = 1'b1;
    end
    check("cont_hold_forever", 8'(bad), 8'h0);
    req_h0 = 4'b0000;
    tick();
    check("cont_release", 8'(grant_h0), 8'h0);

    // Fresh reset so the rotation pointer starts at requester 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    req_h0 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_grant", 8'(grant_h0), 8'(rr_exp[i]));
      check("rr_gcode", 8'(gcode_h0), 8'(rr_code[i]));
      tick();
      req_h0 = 4'b1111 & ~rr_exp[i];
      tick();
      check("rr_release", 8'(grant_h0), 8'h0);
      req_h0 = 4'b1111;
    end
    req_h0 = 4'b0000;
    tick();

    // Timeout after 4 cycles, then mask
    req_h4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_hold_grant", 8'(grant_h4),   8'b1000);
      check("to_hold_pulse", 8'(timeout_h4), 8'h0);
    end
    tick();
    check("to_pulse",       8'(timeout_h4), 8'h1);
    check("to_grant_clear", 8'(grant_h4),   8'h0);
    check("to_busy_clear",  8'(busy_h4),    8'h0);
    tick();
    check("mask_grant",     8'(grant_h4),   8'b0001);
    check("mask_gcode",     8'(gcode_h4),   8'b001);
    check("mask_pulse_end", 8'(timeout_h4), 8'h0);
    req_h4 = 4'b0001;
    tick();
    req_h4 = 4'b1000;
    tick();
    check("unmask_release", 8'(grant_h4), 8'h0);
    tick();
    check("unmask_regrant", 8'(grant_h4), 8'b1000);
    req_h4 = 4'b0000;
    tick();

    // Release on the same edge the timeout would fire
    req_h3 = 4'b0100;
    tick();
    tick();
    tick();
    check("coll_cycle3", 8'(grant_h3), 8'b0100);
    req_h3 = 4'b0000;
    tick();
    check("coll_no_pulse", 8'(timeout_h3), 8'h0);
    check("coll_release",  8'(grant_h3),   8'h0);
    req_h3 = 4'b0100;
    tick();
    check("coll_regrant", 8'(grant_h3), 8'b0100);

    // Asynchronous reset between edges during a grant
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 8'(grant_h3), 8'h0);
    check("arst_gcode", 8'(gcode_h3), 8'h0);
    check("arst_busy",  8'(busy_h3),  8'h0);
    @(posedge clk);
    #1;
    check("arst_no_pulse", 8'(timeout_h3), 8'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_grant", 8'(grant_h3), 8'b0100);
    tick();
    tick();
    check("to3_cycle3", 8'(grant_h3), 8'b0100);
    tick();
    check("to3_pulse", 8'(timeout_h3), 8'h1);
    check("to3_clear", 8'(grant_h3),   8'h0);
    req_h3 = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
